bcd_modulo_counter: RTL
=======================

// Module: bcd_modulo_counter
// PURPOSE
// - Generic two-digit BCD-editable modulo counter for the clock datapath: seconds (60), minutes (60), hours (24), etc.
// - Counts on a one-cycle tickIn enable and emits a registered carry pulse on wrap, so stages chain on the single Clk.
// - Supports user editing of the ones/tens digit via active-low push keys when edit mode and the cursor select it.
// PARAMETERS
// - MODULO        60  count range 0..MODULO-1; legal 2..100
// - RESET_VAL     0   value loaded on Rst; must be < MODULO
// - COUNT_DOWN    0   0: up-counter (wrap MODULO-1->0); 1: down-counter (wrap 0->MODULO-1)
// - CUR_ONES      3   editCur code selecting the ones digit
// - CUR_TENS      2   editCur code selecting the tens digit
// - EDIT_DISMODE  0   disMode code in which editing is permitted
// - WIDTH         $clog2(MODULO)  derived localparam, not overridable
// PORTS
// - Clk       in   1      single system clock, rising edge
// - Rst       in   1      synchronous active-high reset
// - tickIn    in   1      count enable, one-cycle pulse from previous stage or prescaler
// - KEY       in   4      raw push keys, active low; KEY[1]=increment, KEY[2]=decrement; KEY[0],KEY[3] unused
// - editMode  in   1      1: editing, counting frozen
// - editCur   in   3      edit cursor position
// - disMode   in   2      current display mode
// - value     out  WIDTH  binary count
// - bcdOnes   out  4      value % 10 (combinational from value)
// - bcdTens   out  4      value / 10 (combinational from value)
// - carryOut  out  1      registered one-cycle wrap/borrow pulse
// - atTerm    out  1      combinational: value==MODULO-1 (up) or value==0 (down)
// BEHAVIOUR
// - Reset: value=RESET_VAL, carryOut=0, key sync/history flops=1 (released); synchronous, overrides all activity same edge.
// - Keys: each of KEY[1],KEY[2] passes a 2-flop synchroniser plus history flop; press event = history&~sync2, one cycle wide.
// - Latency: KEY low first sampled at edge N -> value updated at edge N+2. Holding a key gives exactly one event; release re-arms.
// - Edit enable: editEn = editMode && disMode==EDIT_DISMODE; digit = editCur==CUR_ONES / CUR_TENS; other codes ignore keys.
// - Priority per edge: Rst > inc event > dec event > tickIn. Simultaneous inc+dec events: inc applied, dec dropped.
// - Digit limits: tMax=(MODULO-1)/10; oMax(t)= (t==tMax) ? (MODULO-1)%10 : 9.
// - Ones inc: o==oMax(t) ? o=0 : o+1. Ones dec: o==0 ? o=oMax(t) : o-1. Tens unchanged.
// - Tens inc: t==tMax ? t=0 : t+1. Tens dec: t==0 ? t=tMax : t-1. After tens change, if o>oMax(new t) clamp o=oMax(new t).
// - Editing never produces carryOut; value always < MODULO after any operation.
// - Counting: only when editMode==0 and tickIn==1. Up: value==MODULO-1 -> 0 else +1. Down: value==0 -> MODULO-1 else -1.
// - carryOut=1 on the cycle following the wrapping tick edge (registered with the wrap), else 0; never two consecutive cycles unless tickIn is.
// - editMode==1: tickIn ignored, no carry; key events ignored when editMode==0.
// - editMode/editCur/disMode change mid-press: evaluated at the event cycle only; no queued events.
// - Rst asserted mid-press: sync flops forced to 1; a key still held after Rst release produces no event until released and pressed again.
// STRUCTURE
// - clock_pkg: EDIT_CUR_* codes, DISMODE_* codes, key index constants KEY_INC=1/KEY_DEC=2, function bcd_split().
// - Sub-module key_edge_detect (sync + falling-edge pulse, active-low in, one instance per key); counter/edit logic in this module.
// TESTING
// - Reset: MODULO=60, RESET_VAL=59, Rst 1 cycle -> value=59, carryOut=0, atTerm=1; KEY held low during Rst -> no edit after release.
// - Count/wrap: editMode=0, tickIn pulse at value=59 -> value=0, carryOut=1 for exactly one cycle; next tick -> 1, carryOut=0.
// - Ones edit: editMode=1,disMode=0,editCur=3, value=49, press KEY[1] -> 40 at edge N+2; press KEY[2] at 40 -> 49; held key -> single step.
// - Tens edit MODULO=24: value=19, editCur=2, KEY[1] -> 23 (clamped from 29); KEY[1] again -> 3; KEY[2] at 3 -> 23.
// - Down mode COUNT_DOWN=1, MODULO=60: value=0, tickIn -> 59, carryOut=1; editMode=1 with tickIn high 10 cycles -> value unchanged, no carry.
// - Priority: inc+dec events same cycle with tickIn at value=15 (ones cursor) -> 16; editCur=5 or disMode=1 -> key events ignored, value 15.

Source files
------------

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants and helpers for the clock datapath counters.
//   EDIT_CUR_*  : edit cursor codes selecting a digit
//   DISMODE_*   : display mode codes
//   KEY_INC/DEC : indices of the increment / decrement push keys
//   bcd_split() : binary 0..99 -> {tens, ones} BCD digits
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam logic [2:0] EDIT_CUR_TENS = 3'd2;
  localparam logic [2:0] EDIT_CUR_ONES = 3'd3;

  localparam logic [1:0] DISMODE_TIME  = 2'd0;

  localparam int KEY_INC = 1;
  localparam int KEY_DEC = 2;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  // Valid for 0..99, which covers every legal counter range.
  function automatic bcd_pair_t bcd_split(input logic [6:0] bin);
    bcd_pair_t r;
    r.tens = 4'(bin / 7'd10);
    r.ones = 4'(bin % 7'd10);
    return r;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// -----------------------------------------------------------------------------
// key_edge_detect
// Two-flop synchroniser plus history flop for one raw active-low push key,
// producing a one-cycle press pulse on the synchronised falling edge.
// A key already held when reset is released is ignored until it has been
// seen released, so a press spanning reset never generates an event.
//   Clk     : system clock, rising edge
//   Rst     : synchronous active-high reset
//   key_n_i : raw key, active low, asynchronous
//   press_o : one-cycle press pulse
// -----------------------------------------------------------------------------
module key_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic key_n_i,
  output logic press_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       hist_q;
  logic [1:0] vld_q;     // shift of 1s: sync2_q holds a real key sample once vld_q[1] is set
  logic       armed_q;   // key has been seen released since reset

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (sync chain ordering).
    if (Rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & sync2_q);
    end
  end

  assign press_o = armed_q & hist_q & ~sync2_q;

endmodule

// File: rtl/bcd_modulo_counter.sv
// -----------------------------------------------------------------------------
// bcd_modulo_counter
// Two-digit BCD-editable modulo counter (seconds/minutes/hours stage).
// Counts on tickIn, emits a registered carry pulse on wrap, and lets the
// user step the ones or tens digit with the increment/decrement keys.
//   Clk      : system clock, rising edge
//   Rst      : synchronous active-high reset
//   tickIn   : count enable pulse
//   KEY      : raw active-low keys; KEY[1]=inc, KEY[2]=dec
//   editMode : 1 = editing, counting frozen
//   editCur  : edit cursor position
//   disMode  : display mode
//   value    : binary count 0..MODULO-1
//   bcdOnes  : value % 10
//   bcdTens  : value / 10
//   carryOut : registered one-cycle wrap/borrow pulse
//   atTerm   : value at terminal count for the counting direction
// -----------------------------------------------------------------------------
module bcd_modulo_counter
  import clock_pkg::*;
#(
  parameter int         MODULO       = 60,
  parameter int         RESET_VAL    = 0,
  parameter bit         COUNT_DOWN   = 1'b0,
  parameter logic [2:0] CUR_ONES     = EDIT_CUR_ONES,
  parameter logic [2:0] CUR_TENS     = EDIT_CUR_TENS,
  parameter logic [1:0] EDIT_DISMODE = DISMODE_TIME,
  localparam int        WIDTH        = $clog2(MODULO)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             tickIn,
  input  logic [3:0]       KEY,
  input  logic             editMode,
  input  logic [2:0]       editCur,
  input  logic [1:0]       disMode,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       bcdOnes,
  output logic [3:0]       bcdTens,
  output logic             carryOut,
  output logic             atTerm
);

  localparam logic [WIDTH-1:0] MOD_M1   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RESET_VAL);
  localparam logic [3:0]       TMAX     = 4'((MODULO - 1) / 10);
  localparam logic [3:0]       OMAX_TOP = 4'((MODULO - 1) % 10);

  // Highest legal ones digit for a given tens digit.
  function automatic logic [3:0] omax(input logic [3:0] t);
    return (t == TMAX) ? OMAX_TOP : 4'd9;
  endfunction

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             inc_ev, dec_ev;
  logic             edit_en, sel_ones, sel_tens;
  logic [3:0]       ones_new, tens_new;
  bcd_pair_t        cur;

  logic unused_keys;
  assign unused_keys = KEY[0] ^ KEY[3];

  key_edge_detect u_key_inc (
    .Clk     (Clk),
    .Rst     (Rst),
    .key_n_i (KEY[KEY_INC]),
    .press_o (inc_ev)
  );

  key_edge_detect u_key_dec (
    .Clk     (Clk),
    .Rst     (Rst),
    .key_n_i (KEY[KEY_DEC]),
    .press_o (dec_ev)
  );

  assign cur      = bcd_split(7'(value_q));
  assign edit_en  = editMode && (disMode == EDIT_DISMODE);
  assign sel_ones = (editCur == CUR_ONES);
  assign sel_tens = (editCur == CUR_TENS);
  assign atTerm   = COUNT_DOWN ? (value_q == '0) : (value_q == MOD_M1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    value_d  = value_q;
    carry_d  = 1'b0;
    ones_new = cur.ones;
    tens_new = cur.tens;

    if (edit_en && (sel_ones || sel_tens) && (inc_ev || dec_ev)) begin
      // Simultaneous events: inc wins because it is tested first.
      if (sel_ones) begin
        if (inc_ev) ones_new = (cur.ones == omax(cur.tens)) ? 4'd0 : cur.ones + 4'd1;
        else        ones_new = (cur.ones == 4'd0) ? omax(cur.tens) : cur.ones - 4'd1;
      end else begin
        if (inc_ev) tens_new = (cur.tens == TMAX) ? 4'd0 : cur.tens + 4'd1;
        else        tens_new = (cur.tens == 4'd0) ? TMAX : cur.tens - 4'd1;
        // Moving into the top tens digit may make the ones digit illegal.
        if (cur.ones > omax(tens_new)) ones_new = omax(tens_new);
      end
      value_d = WIDTH'(7'(tens_new) * 7'd10 + 7'(ones_new));
    end else if (!editMode && tickIn) begin
      if (COUNT_DOWN) value_d = atTerm ? MOD_M1 : value_q - WIDTH'(1);
      else            value_d = atTerm ? '0     : value_q + WIDTH'(1);
      carry_d = atTerm;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      value_q <= RST_V;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value    = value_q;
  assign carryOut = carry_q;
  assign bcdOnes  = cur.ones;
  assign bcdTens  = cur.tens;

endmodule
